// File: rtl/sc_statemachinepoint_repeat_pkg.sv
// Shared definitions for the point-control state machine with hold-to-repeat:
// state encoding, shift-select codes and the latched-command encoding.
package sc_statemachinepoint_repeat_pkg;

    // 4-bit state codes
    localparam logic [3:0] S_RESET   = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_CHECK   = 4'd2;
    localparam logic [3:0] S_INIT    = 4'd3;
    localparam logic [3:0] S_UP      = 4'd4;
    localparam logic [3:0] S_DOWN    = 4'd5;
    localparam logic [3:0] S_LEFT    = 4'd6;
    localparam logic [3:0] S_RIGHT   = 4'd7;
    localparam logic [3:0] S_HOLD    = 4'd8;
    localparam logic [3:0] S_RELEASE = 4'd9;

    typedef enum logic [3:0] {
        ST_RESET   = S_RESET,
        ST_START   = S_START,
        ST_CHECK   = S_CHECK,
        ST_INIT    = S_INIT,
        ST_UP      = S_UP,
        ST_DOWN    = S_DOWN,
        ST_LEFT    = S_LEFT,
        ST_RIGHT   = S_RIGHT,
        ST_HOLD    = S_HOLD,
        ST_RELEASE = S_RELEASE
    } state_t;

    // shiftselection_Out codes
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    // Command remembered while a button is held
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_INIT  = 3'd1,
        CMD_UP    = 3'd2,
        CMD_DOWN  = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5
    } cmd_t;

    // Command state that issues a given command; CHECK for "no command".
    function automatic state_t cmd_state(input cmd_t c);
        state_t s;
        s = ST_CHECK;
        case (c)
            CMD_INIT:  s = ST_INIT;
            CMD_UP:    s = ST_UP;
            CMD_DOWN:  s = ST_DOWN;
            CMD_LEFT:  s = ST_LEFT;
            CMD_RIGHT: s = ST_RIGHT;
            default:   s = ST_CHECK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sc_statemachinepoint_repeat_timer.sv
// Hold-to-repeat interval timer: counts up from zero after a clear and
// saturates at the selected limit (first-repeat delay or repeat rate).
module sc_repeat_timer
    import sc_statemachinepoint_repeat_pkg::*;
#(
    parameter int               CNT_W       = 4,
    parameter logic [CNT_W-1:0] FIRST_LIMIT = '1,
    parameter logic [CNT_W-1:0] RATE_LIMIT  = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_In,
    input  logic inc_In,
    input  logic rate_sel_In,
    output logic done_Out
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit;

    assign limit    = rate_sel_In ? RATE_LIMIT : FIRST_LIMIT;
    // Limit is only switched together with a clear, so >= and == agree;
    // >= keeps the flag safe if the count ever sits above a smaller limit.
    assign done_Out = (cnt_q >= limit);

    // Clear wins over increment; increment stops at the limit (no wrap).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_In) begin
            cnt_d = '0;
        end else if (inc_In && !done_Out) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_statemachinepoint_repeat.sv
// Point-control state machine: turns active-low buttons into one-cycle
// clear/load/shift commands, with boundary guards and hold-to-repeat.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  RESET   | entered on reset, outputs idle
//  START   | one idle cycle after reset
//  CHECK   | waiting for a request (start > up > down > left > right)
//  INIT    | clear_OutLow active for one cycle
//  UP      | load0_OutLow active for one cycle
//  DOWN    | load1_OutLow active for one cycle
//  LEFT    | shift left for one cycle
//  RIGHT   | shift right for one cycle
//  HOLD    | button still held; timing the next auto-repeat
//  RELEASE | one idle cycle after all buttons are released
module sc_statemachinepoint_repeat #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1)
) (
    input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       up_InLow,
    input  logic       down_InLow,
    input  logic       left_InLow,
    input  logic       right_InLow,
    input  logic       repeat_en_In,
    input  logic       topside_InLow,
    input  logic       bottomside_InLow,
    input  logic       leftside_InLow,
    input  logic       rightside_InLow,
    output logic       clear_OutLow,
    output logic       load0_OutLow,
    output logic       load1_OutLow,
    output logic [1:0] shiftselection_Out,
    output logic       repeating_Out
);

    import sc_statemachinepoint_repeat_pkg::*;

    state_t state_q;
    state_t state_d;
    cmd_t   cmd_q;
    cmd_t   cmd_d;
    logic   rate_sel_q;
    logic   rate_sel_d;
    logic   repeating_q;
    logic   repeating_d;

    logic   tmr_clr;
    logic   tmr_inc;
    logic   tmr_done;

    logic   all_released;
    logic   cmd_btn_low;
    logic   cmd_open;
    cmd_t   check_req;

    sc_repeat_timer #(
        .CNT_W      (CNT_W),
        .FIRST_LIMIT(CNT_W'(REPEAT_DELAY - 1)),
        .RATE_LIMIT (CNT_W'(REPEAT_RATE - 1))
    ) u_timer (
        .clk        (SC_STATEMACHINEPOINT_CLOCK_50),
        .rst        (SC_STATEMACHINEPOINT_RESET_InHigh),
        .clr_In     (tmr_clr),
        .inc_In     (tmr_inc),
        .rate_sel_In(rate_sel_q),
        .done_Out   (tmr_done)
    );

    assign all_released = start_InLow & up_InLow & down_InLow & left_InLow & right_InLow;

    // Button/boundary view of the latched command, and the prioritised request seen in CHECK.
    always_comb begin
        cmd_btn_low = 1'b0;
        cmd_open    = 1'b0;
        case (cmd_q)
            CMD_INIT: begin
                cmd_btn_low = !start_InLow;
                cmd_open    = 1'b1;
            end
            CMD_UP: begin
                cmd_btn_low = !up_InLow;
                cmd_open    = topside_InLow;
            end
            CMD_DOWN: begin
                cmd_btn_low = !down_InLow;
                cmd_open    = bottomside_InLow;
            end
            CMD_LEFT: begin
                cmd_btn_low = !left_InLow;
                cmd_open    = leftside_InLow;
            end
            CMD_RIGHT: begin
                cmd_btn_low = !right_InLow;
                cmd_open    = rightside_InLow;
            end
            default: begin
                cmd_btn_low = 1'b0;
                cmd_open    = 1'b0;
            end
        endcase

        check_req = CMD_NONE;
        if (!start_InLow) begin
            check_req = CMD_INIT;
        end else if (!up_InLow && topside_InLow) begin
            check_req = CMD_UP;
        end else if (!down_InLow && bottomside_InLow) begin
            check_req = CMD_DOWN;
        end else if (!left_InLow && leftside_InLow) begin
            check_req = CMD_LEFT;
        end else if (!right_InLow && rightside_InLow) begin
            check_req = CMD_RIGHT;
        end
    end

    // Next-state logic, command latch, repeat bookkeeping and timer control.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rate_sel_d  = rate_sel_q;
        repeating_d = repeating_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (check_req != CMD_NONE) begin
                    state_d    = cmd_state(check_req);
                    cmd_d      = check_req;
                    rate_sel_d = 1'b0;
                    tmr_clr    = 1'b1;
                end
            end
            ST_INIT, ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT: begin
                // The command cycle is the first counted cycle of the interval.
                tmr_inc = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                tmr_inc = 1'b1;
                if (all_released) begin
                    state_d     = ST_RELEASE;
                    repeating_d = 1'b0;
                end else if (cmd_btn_low && (cmd_q != CMD_INIT) && repeat_en_In && tmr_done) begin
                    // Whether issued or blocked, the next attempt is one rate interval away.
                    tmr_clr    = 1'b1;
                    rate_sel_d = 1'b1;
                    if (cmd_open) begin
                        state_d     = cmd_state(cmd_q);
                        repeating_d = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_CHECK;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State and bookkeeping registers, asynchronously reset to idle.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            state_q     <= ST_RESET;
            cmd_q       <= CMD_NONE;
            rate_sel_q  <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rate_sel_q  <= rate_sel_d;
            repeating_q <= repeating_d;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        clear_OutLow       = 1'b1;
        load0_OutLow       = 1'b1;
        load1_OutLow       = 1'b1;
        shiftselection_Out = SHIFT_HOLD;
        case (state_q)
            ST_INIT:  clear_OutLow       = 1'b0;
            ST_UP:    load0_OutLow       = 1'b0;
            ST_DOWN:  load1_OutLow       = 1'b0;
            ST_LEFT:  shiftselection_Out = SHIFT_LEFT;
            ST_RIGHT: shiftselection_Out = SHIFT_RIGHT;
            default: begin
                clear_OutLow       = 1'b1;
                load0_OutLow       = 1'b1;
                load1_OutLow       = 1'b1;
                shiftselection_Out = SHIFT_HOLD;
            end
        endcase
    end

    assign repeating_Out = repeating_q;

endmodule
